// File: rtl/unshuffle_writer.sv
// unshuffle_writer
//   Pixel-unshuffle (space-to-depth) front end. A raster-order stream of
//   IMG_W x IMG_H pixels (IN_CH channels each) is scattered into four SRAM
//   banks. Each SRAM word holds a 2x2 tile of the unshuffled map across all
//   CH_NUM = 4*IN_CH channels. One write is issued per accepted input beat.
//
//   Optional feature macro: UNSHUFFLE_PINGPONG_EN
//     defined   : a frame-select bit toggles after every frame and drives the
//                 address MSB, so consecutive frames alternate SRAM halves.
//     undefined : every frame writes from base address 0.
//
//   Ports
//     clk            rising-edge clock
//     rst            synchronous active-high reset
//     start          frame start pulse, sampled only in IDLE
//     in_valid       input beat valid (no backpressure in FILL)
//     in_data        one pixel, channel k at [(IN_CH-k)*BW-1 -: BW]
//     busy           high while a frame is being filled
//     done           one-cycle pulse after the last write of a frame
//     sram_wen       per-bank write enable, active-low
//     sram_bytemask  per-lane mask, active-low (0 = write lane)
//     sram_waddr     write address shared by all banks
//     sram_wdata     write data, lane 0 in the MSBs
module unshuffle_writer #(
  parameter int IMG_W        = 28,
  parameter int IMG_H        = 28,
  parameter int IN_CH        = 1,
  parameter int CH_NUM       = 4,
  parameter int ACT_PER_ADDR = 4,
  parameter int BW_PER_ACT   = 8,
  parameter int ADDR_W       = 6
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       start,
  input  logic                                       in_valid,
  input  logic [IN_CH*BW_PER_ACT-1:0]                in_data,
  output logic                                       busy,
  output logic                                       done,
  output logic [3:0]                                 sram_wen,
  output logic [CH_NUM*ACT_PER_ADDR-1:0]             sram_bytemask,
  output logic [ADDR_W-1:0]                          sram_waddr,
  output logic [CH_NUM*ACT_PER_ADDR*BW_PER_ACT-1:0]  sram_wdata
);

  localparam int LANES    = CH_NUM * ACT_PER_ADDR;
  localparam int WORD_W   = LANES * BW_PER_ACT;
  localparam int COL_W    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int ROW_W    = (IMG_H > 1) ? $clog2(IMG_H + 1) : 1;
  // Words per address row: two word columns (banks) share one address.
  localparam int WPR      = (IMG_W + 7) / 8;
  localparam int MAX_ADDR = ((IMG_H / 4 - 1) / 2) * WPR + (IMG_W / 4 - 1) / 2;
`ifdef UNSHUFFLE_PINGPONG_EN
  localparam int ADDR_SPAN = 1 << (ADDR_W - 1);
`else
  localparam int ADDR_SPAN = 1 << ADDR_W;
`endif

  generate
    if ((IMG_W % 4) != 0 || (IMG_H % 4) != 0) begin : g_bad_dim
      $fatal(1, "unshuffle_writer: IMG_W and IMG_H must be multiples of 4");
    end
    if (CH_NUM != 4 * IN_CH || ACT_PER_ADDR != 4) begin : g_bad_ch
      $fatal(1, "unshuffle_writer: CH_NUM must be 4*IN_CH and ACT_PER_ADDR 4");
    end
    if (MAX_ADDR >= ADDR_SPAN) begin : g_bad_addr
      $fatal(1, "unshuffle_writer: frame does not fit in ADDR_W address bits");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_DONE} state_t;

  state_t            state, state_nxt;
  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;
  logic              accept_p0;
  logic              last_p0;
  logic [ADDR_W-1:0] base;

  assign accept_p0 = (state == S_FILL) && in_valid;
  assign last_p0   = accept_p0 && (col == COL_W'(IMG_W - 1))
                               && (row == ROW_W'(IMG_H - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_FILL;
      S_FILL:  if (last_p0) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign busy = (state == S_FILL);
  assign done = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (state == S_IDLE && start) begin
      col <= '0;
      row <= '0;
    end else if (accept_p0) begin
      if (col == COL_W'(IMG_W - 1)) begin
        col <= '0;
        row <= row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

`ifdef UNSHUFFLE_PINGPONG_EN
  logic frame_sel;

  always_ff @(posedge clk) begin
    if (rst)                 frame_sel <= 1'b0;
    else if (state == S_DONE) frame_sel <= ~frame_sel;
  end

  assign base = {frame_sel, {(ADDR_W - 1){1'b0}}};
`else
  assign base = '0;
`endif

  // ---- stage p0: map (row, col) to bank / address / lanes ----
  // Successive halvings of row and column peel off one bit each:
  // bit 0 selects the sub-pixel channel group, bit 1 the activation inside
  // the 2x2 tile, bit 2 the bank, the remaining bits the address.
  logic [31:0]             r32, c32, addr32, lane;
  logic [1:0]              q_p0, act_p0, bank_p0;
  logic [BW_PER_ACT-1:0]   pix;
  logic [WORD_W-1:0]       wdata_p0;
  logic [LANES-1:0]        mask_p0;

  assign r32     = 32'(row);
  assign c32     = 32'(col);
  assign q_p0    = {r32[0], c32[0]};
  assign act_p0  = {r32[1], c32[1]};
  assign bank_p0 = {r32[2], c32[2]};
  assign addr32  = (r32 >> 3) * 32'(WPR) + (c32 >> 3);

  always_comb begin
    wdata_p0 = '0;
    mask_p0  = '1;
    lane     = '0;
    pix      = '0;
    for (int k = 0; k < IN_CH; k++) begin
      lane     = (32'(q_p0) * 32'(IN_CH) + 32'(k)) * 32'(ACT_PER_ADDR) + 32'(act_p0);
      pix      = BW_PER_ACT'(in_data >> ((IN_CH - 1 - k) * BW_PER_ACT));
      wdata_p0 = wdata_p0 | (WORD_W'(pix) << (WORD_W - BW_PER_ACT - lane * BW_PER_ACT));
      mask_p0  = mask_p0 & ~(LANES'(1) << (LANES - 1 - lane));
    end
  end

  // ---- stage p1: registered SRAM write port ----
  // Address and data hold between writes; only wen/bytemask define a write.
  always_ff @(posedge clk) begin
    if (rst) begin
      sram_wen      <= 4'b1111;
      sram_bytemask <= '1;
      sram_waddr    <= '0;
      sram_wdata    <= '0;
    end else if (accept_p0) begin
      sram_wen      <= ~(4'b0001 << bank_p0);
      sram_bytemask <= mask_p0;
      sram_waddr    <= ADDR_W'(addr32) | base;
      sram_wdata    <= wdata_p0;
    end else begin
      sram_wen      <= 4'b1111;
      sram_bytemask <= '1;
    end
  end

endmodule

// File: tb/tb_unshuffle_writer.sv
`timescale 1ns/1ps
module tb_unshuffle_writer;

  localparam int IMG_W  = 28;
  localparam int IMG_H  = 28;
  localparam int IN_CH  = 1;
  localparam int APA    = 4;
  localparam int BW     = 8;
  localparam int ADDR_W = 6;
  localparam int LANES  = 16;
  localparam int WORD_W = 128;
  localparam int NPIX   = IMG_W * IMG_H;
  localparam int WPR    = (IMG_W + 7) / 8;
`ifdef UNSHUFFLE_PINGPONG_EN
  localparam bit PP = 1'b1;
`else
  localparam bit PP = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst, start, in_valid;
  logic [7:0]   in_data;
  logic         busy, done;
  logic [3:0]   sram_wen;
  logic [15:0]  sram_bytemask;
  logic [5:0]   sram_waddr;
  logic [127:0] sram_wdata;

  always #5 clk = ~clk;

  unshuffle_writer dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .busy(busy), .done(done), .sram_wen(sram_wen), .sram_bytemask(sram_bytemask),
    .sram_waddr(sram_waddr), .sram_wdata(sram_wdata)
  );

  int errors = 0;
  int checks = 0;

  // Behavioural model: 0 = idle, 1 = filling, 2 = done; beats counted linearly.
  int   m_state = 0;
  int   m_beats = 0;
  bit   m_sel   = 1'b0;
  bit   chk_en  = 1'b0;
  logic [3:0]   e_wen;
  logic [15:0]  e_mask;
  logic [5:0]   e_addr;
  logic [127:0] e_data;
  logic         e_busy, e_done;

  logic [7:0] pix [NPIX];
  logic [7:0] mem [4][64][16];
  bit         wrt [4][64][16];

  // Forward unshuffle: raster index -> bank, address, lane.
  function automatic void map_pix(input int p, input int k,
                                  output int bank, output int addr, output int lane);
    int r, c, ur, uc, wr, wc;
    r = p / IMG_W;  c = p % IMG_W;
    ur = r / 2;     uc = c / 2;
    wr = ur / 2;    wc = uc / 2;
    lane = ((2 * (r % 2) + (c % 2)) * IN_CH + k) * APA + 2 * (ur % 2) + (uc % 2);
    bank = 2 * (wr % 2) + (wc % 2);
    addr = (wr / 2) * WPR + wc / 2;
  endfunction

  // Inverse: SRAM cell -> source pixel, used for the whole-frame golden check.
  function automatic void unmap(input int bank, input int addr, input int lane,
                                output int r, output int c, output int k);
    int ch, act, q, wr, wc, ur, uc;
    ch = lane / APA;  act = lane % APA;
    q  = ch / IN_CH;  k   = ch % IN_CH;
    wr = 2 * (addr / WPR) + bank / 2;
    wc = 2 * (addr % WPR) + bank % 2;
    ur = 2 * wr + act / 2;
    uc = 2 * wc + act % 2;
    r  = 2 * ur + q / 2;
    c  = 2 * uc + q % 2;
  endfunction

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", nm, got, exp);
    end
  endtask

  // Drive one cycle of inputs, advance the model, and publish what the DUT
  // outputs must be after the coming edge.
  task automatic cycle(input bit st, input bit v, input logic [7:0] d, input bit rs,
                       output bit acc, output int acc_p);
    int bank, addr, lane;
    logic [3:0]   n_wen;
    logic [15:0]  n_mask;
    logic [5:0]   n_addr;
    logic [127:0] n_data;
    start = st; in_valid = v; in_data = d; rst = rs;
    n_wen = 4'hF; n_mask = 16'hFFFF; n_addr = '0; n_data = '0;
    acc = 1'b0; acc_p = -1;
    if (rs) begin
      m_state = 0; m_beats = 0; m_sel = 1'b0;
    end else begin
      case (m_state)
        0: if (st) begin m_state = 1; m_beats = 0; end
        1: if (v) begin
             map_pix(m_beats, 0, bank, addr, lane);
             n_wen  = ~(4'b0001 << bank);
             n_mask = ~(16'h0001 << (LANES - 1 - lane));
             n_addr = 6'(addr + (m_sel ? 32 : 0));
             n_data = 128'(d) << (WORD_W - BW - lane * BW);
             pix[m_beats] = d;
             acc = 1'b1; acc_p = m_beats;
             m_beats++;
             if (m_beats == NPIX) m_state = 2;
           end
        default: begin
          m_state = 0;
          if (PP) m_sel = ~m_sel;
        end
      endcase
    end
    @(posedge clk); #1;
    e_wen = n_wen; e_mask = n_mask; e_addr = n_addr; e_data = n_data;
    e_busy = (m_state == 1); e_done = (m_state == 2);
    chk_en = 1'b1;
  endtask

  task automatic idle_cycles(input int n, input bit v);
    bit a; int ap;
    for (int i = 0; i < n; i++) cycle(1'b0, v, 8'($urandom), 1'b0, a, ap);
  endtask

  // Single compare process against the model, plus SRAM image capture.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin : cmp
        bit ok;
        ok = (sram_wen === e_wen) && (sram_bytemask === e_mask) &&
             (busy === e_busy) && (done === e_done);
        if (e_wen != 4'hF) ok = ok && (sram_waddr === e_addr) && (sram_wdata === e_data);
        checks++;
        if (!ok) begin
          errors++;
          $display("FAIL cycle t=%0t: wen %b/%b mask %h/%h busy %b/%b done %b/%b addr %0d/%0d data %h/%h (got/required)",
                   $time, sram_wen, e_wen, sram_bytemask, e_mask, busy, e_busy, done, e_done,
                   sram_waddr, e_addr, sram_wdata, e_data);
        end
        for (int b = 0; b < 4; b++)
          if (!sram_wen[b[1:0]])
            for (int l = 0; l < 16; l++)
              if (!sram_bytemask[4'(15 - l)]) begin
                mem[b][sram_waddr][l] = 8'(sram_wdata >> (WORD_W - BW - l * BW));
                wrt[b][sram_waddr][l] = 1'b1;
              end
      end
    end
  end

  task automatic clear_mem();
    for (int b = 0; b < 4; b++)
      for (int a = 0; a < 64; a++)
        for (int l = 0; l < 16; l++) wrt[b][a][l] = 1'b0;
  endtask

  task automatic golden(input string nm, input int base);
    int bad, cells, r, c, k, span;
    bad = 0; cells = 0;
    span = PP ? 32 : 64;
    for (int b = 0; b < 4; b++)
      for (int a = 0; a < 64; a++)
        for (int l = 0; l < 16; l++) begin
          if (a >= base && a < base + span) begin
            unmap(b, a - base, l, r, c, k);
            if (r < IMG_H && c < IMG_W && k == 0) begin
              if (wrt[b][a][l] && mem[b][a][l] === pix[r * IMG_W + c]) cells++;
              else bad++;
            end else if (wrt[b][a][l]) bad++;
          end else if (wrt[b][a][l]) bad++;
        end
    chk({nm, "_bad_cells"}, 128'(bad), 128'(0));
    chk({nm, "_cells"}, 128'(cells), 128'(NPIX));
  endtask

  task automatic lit_pixel(input int mode, input int p);
    if (mode == 1) begin
      case (p)
        0: begin
          chk("p0_wen", 128'(sram_wen), 128'(4'b1110));
          chk("p0_addr", 128'(sram_waddr), 128'(0));
          chk("p0_mask", 128'(sram_bytemask), 128'(16'h7FFF));
          chk("p0_data", sram_wdata, {8'h11, 120'h0});
        end
        1: begin
          chk("p1_mask", 128'(sram_bytemask), 128'(16'hF7FF));
          chk("p1_data", sram_wdata, 128'h22 << 88);
        end
        2: chk("p2_mask", 128'(sram_bytemask), 128'(16'hBFFF));
        4: begin
          chk("p4_wen", 128'(sram_wen), 128'(4'b1101));
          chk("p4_mask", 128'(sram_bytemask), 128'(16'h7FFF));
        end
        112: begin
          chk("p112_wen", 128'(sram_wen), 128'(4'b1011));
          chk("p112_addr", 128'(sram_waddr), 128'(0));
        end
        783: begin
          chk("p783_wen", 128'(sram_wen), 128'(4'b1110));
          chk("p783_addr", 128'(sram_waddr), 128'(15));
          chk("p783_mask", 128'(sram_bytemask), 128'(16'hFFFE));
          chk("p783_data", sram_wdata, 128'hAB);
        end
        default: ;
      endcase
    end else if (mode == 2 && p == 0) begin
      chk("after_rst_p0_wen", 128'(sram_wen), 128'(4'b1110));
      chk("after_rst_p0_addr", 128'(sram_waddr), 128'(0));
    end else if (mode == 3 && p == 0) begin
      chk("frame2_p0_addr", 128'(sram_waddr), PP ? 128'(32) : 128'(0));
    end
  endtask

  // One frame: start, beats with optional random gaps and stray starts,
  // optional reset at beat stop_at, then a DONE cycle with misuse inputs.
  task automatic run_frame(input int gap_pct, input int stop_at, input int mode,
                           output int base);
    logic [7:0] d;
    int p, ap;
    bit a, st;
    cycle(1'b1, 1'b0, 8'h00, 1'b0, a, ap);
    base = m_sel ? 32 : 0;
    p = 0;
    while (p < NPIX) begin
      st = (gap_pct > 0) && ($urandom_range(0, 3) == 0);
      if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
        cycle(st, 1'b0, 8'($urandom), 1'b0, a, ap);
      end else begin
        d = 8'($urandom);
        if (mode == 1) begin
          case (p)
            0: d = 8'h11;  1: d = 8'h22;  2: d = 8'h33;
            4: d = 8'h44;  783: d = 8'hAB;
            default: ;
          endcase
        end
        cycle(st, 1'b1, d, (p == stop_at), a, ap);
        if (p == stop_at) return;
        lit_pixel(mode, p);
        p++;
      end
    end
    if (mode == 1) begin
      chk("last_done", 128'(done), 128'(1));
      chk("last_busy", 128'(busy), 128'(0));
    end
    cycle(1'b1, 1'b1, 8'h5A, 1'b0, a, ap);
    if (mode == 1) chk("done_one_cycle", 128'(done), 128'(0));
  endtask

  initial begin
    int b, ad, l, r, c, k, base;
    bit a; int ap;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;

    repeat (3) cycle(1'b0, 1'b0, 8'h00, 1'b1, a, ap);
    chk("rst_wen", 128'(sram_wen), 128'(4'hF));
    chk("rst_mask", 128'(sram_bytemask), 128'(16'hFFFF));
    chk("rst_addr", 128'(sram_waddr), 128'(0));
    chk("rst_data", sram_wdata, 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_done", 128'(done), 128'(0));

    // Pin the reference mapping with hand-derived values.
    map_pix(783, 0, b, ad, l);
    chk("model_783_bank", 128'(b), 128'(0));
    chk("model_783_addr", 128'(ad), 128'(15));
    chk("model_783_lane", 128'(l), 128'(15));
    map_pix(4 * IMG_W, 0, b, ad, l);
    chk("model_112_bank", 128'(b), 128'(2));
    unmap(0, 15, 15, r, c, k);
    chk("model_unmap_r", 128'(r), 128'(27));
    chk("model_unmap_c", 128'(c), 128'(27));

    idle_cycles(5, 1'b1);                 // in_valid without start: no writes
    clear_mem();
    run_frame(25, -1, 1, base);
    golden("frame1", base);
    idle_cycles(4, 1'b1);

    run_frame(10, 300, 0, base);          // reset lands with beat 300
    chk("midrst_wen", 128'(sram_wen), 128'(4'hF));
    chk("midrst_mask", 128'(sram_bytemask), 128'(16'hFFFF));
    chk("midrst_busy", 128'(busy), 128'(0));
    chk("midrst_addr", 128'(sram_waddr), 128'(0));

    clear_mem();
    run_frame(0, -1, 2, base);
    golden("frame3", base);
    clear_mem();
    run_frame(0, -1, 3, base);            // back-to-back frame
    golden("frame4", base);
    idle_cycles(2, 1'b0);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/unshuffle_writer.md
# unshuffle_writer

Parametrised pixel-unshuffle (space-to-depth) front end for the CNN accelerator. It accepts a raster-order image stream of IMG_W x IMG_H pixels, each carrying IN_CH channels, and scatters every activation into activation SRAM group A (four banks). Each SRAM word is a 2x2 tile of the unshuffled map across all CH_NUM = 4*IN_CH channels. Unlike the fixed 28x28 single-channel unshuffle stage, it generalises image size and input channel count, adds an explicit start/done frame handshake, and supports an optional ping-pong frame buffer.

## Interface
- IMG_W, 28, input image width in pixels; multiple of 4.
- IMG_H, 28, input image height in pixels; multiple of 4.
- IN_CH, 1, channels per input pixel.
- CH_NUM, 4, channels per SRAM word; must equal 4*IN_CH.
- ACT_PER_ADDR, 4, activations per channel per word (2x2 tile); fixed at 4.
- BW_PER_ACT, 8, bits per activation.
- ADDR_W, 6, SRAM address width.
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  frame start pulse; sampled only in IDLE.
- in_valid  input  1  input beat valid; no backpressure, every valid beat in FILL is consumed.
- in_data  input  IN_CH*BW_PER_ACT  one pixel; channel k at bits [(IN_CH-k)*BW-1 -: BW].
- busy  output  1  high in FILL.
- done  output  1  one-cycle pulse after the last write of a frame.
- sram_wen  output  4  per-bank write enable, active-low; bit b = bank b.
- sram_bytemask  output  CH_NUM*ACT_PER_ADDR  per-lane mask, active-low (0 = write lane).
- sram_waddr  output  ADDR_W  write address shared by all banks.
- sram_wdata  output  CH_NUM*ACT_PER_ADDR*BW_PER_ACT  write data.

## Operation
- States: IDLE, FILL, DONE. IDLE->FILL on start; FILL->DONE when the IMG_W*IMG_H-th beat is accepted; DONE->IDLE unconditionally after one cycle.
- start in FILL or DONE is ignored; in_valid outside FILL is ignored and generates no write.
- Counters: column c (0..IMG_W-1) and row r (0..IMG_H-1); c increments per accepted beat, wraps to 0 with r+1. Both clear on entering FILL.
- Mapping for pixel (r,c), input channel k: q = 2*(r%2) + (c%2); ch = q*IN_CH + k; ur = r/2, uc = c/2; act = 2*(ur%2) + (uc%2); wr = ur/4... defined as wr = ur/2, wc = uc/2.
- Bank = 2*(wr%2) + (wc%2); address = (wr/2)*ceil(IMG_W/8) + wc/2 (+ frame offset, see Configuration).
- Lane L = ch*ACT_PER_ADDR + act, MSB-first: data at bits [WORD_W-1-L*BW -: BW], mask bit index WORD_W/BW-1-L driven 0.
- Per beat: exactly one bank's wen low, IN_CH mask bits low, all other lanes of sram_wdata zero.
- Designer checks at elaboration: IMG_W%4, IMG_H%4, CH_NUM==4*IN_CH, and max address < 2^ADDR_W (< 2^(ADDR_W-1) with ping-pong); violation is a fatal error.

## Timing
- Reset values: sram_wen 4'b1111, sram_bytemask all ones, sram_waddr 0, sram_wdata 0, busy 0, done 0, state IDLE, counters 0.
- Latency: beat accepted at cycle t -> write outputs registered and valid at t+1, held for one cycle only; cycles with no accepted beat drive wen 4'b1111 and bytemask all ones.
- Last beat accepted at t: its write at t+1, state DONE and done=1 at t+1, busy=0 from t+1; start accepted again from t+2.
- Gaps in in_valid stall counters; frame completes on beat count, not cycles.
- rst mid-frame: next cycle IDLE, counters cleared, no write outputs, partially written SRAM contents left as is.

## Configuration
- UNSHUFFLE_PINGPONG_EN defined: a frame-select bit toggles on every DONE; when 1, address MSB (bit ADDR_W-1) is set, so consecutive frames alternate between lower and upper halves. Frame-select resets to 0.
- Undefined: no frame-select register; every frame writes from base address 0.

## Test plan
- Defaults, start, pixel (0,0)=0x11 -> next cycle wen 4'b1110, waddr 0, bytemask 16'h7FFF, wdata[127:120]=0x11, rest 0.
- Pixels (0,1)=0x22, (0,2)=0x33, (0,4)=0x44 -> masks 16'hF7FF, 16'hBFFF, 16'h7FFF(bank1, wen 4'b1101); pixel (4,0) -> wen 4'b1011, addr 0.
- Full 784-beat frame with random in_valid gaps; pixel (27,27)=0xAB -> bank0, addr 15, mask 16'hFFFE, wdata[7:0]=0xAB; done one cycle after, busy falls same cycle; SRAM model matches golden unshuffle.
- start and in_valid during FILL/DONE/IDLE misuse -> no extra writes, frame beat count unchanged.
- rst asserted at beat 300 -> outputs at reset values next cycle; new start then writes pixel (0,0) to bank0 addr0.
- UNSHUFFLE_PINGPONG_EN: two back-to-back frames -> frame 1 pixel (0,0) at addr 0, frame 2 at addr 32; without macro both at addr 0.
